// File: rtl/mario_motion.sv
// Per-frame player motion controller: velocity/position update for the Mario sprite,
// driven by a synchronized frame pulse and the collision stage's flags and coordinates.
module mario_motion #(
  parameter int X_START     = 32,
  parameter int Y_START     = 400,
  parameter int MAX_RUN_V   = 4,
  parameter int JUMP_V      = 8,
  parameter int JUMP_FRAMES = 12,
  parameter int MAX_FALL_V  = 8,
  parameter int SCROLL_X    = 320,
  parameter int Y_FLOOR     = 463
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_jump,
  input  logic        rightFlag,
  input  logic        leftFlag,
  input  logic        upFlag,
  input  logic        downFlag,
  input  logic [9:0]  collision_right,
  input  logic [9:0]  collision_left,
  input  logic [9:0]  collision_up,
  input  logic [9:0]  collision_down,
  output logic [9:0]  X_Pos,
  output logic [9:0]  Y_Pos,
  output logic [5:0]  Right_V,
  output logic [5:0]  Left_V,
  output logic [5:0]  Up_V,
  output logic [5:0]  Down_V,
  output logic [20:0] logicalX,
  output logic        on_ground
);

  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

  localparam logic [9:0]  L_X0       = 10'(X_START);
  localparam logic [9:0]  L_Y0       = 10'(Y_START);
  localparam logic [5:0]  L_RUN_MAX  = 6'(MAX_RUN_V);
  localparam logic [5:0]  L_JUMP_V   = 6'(JUMP_V);
  localparam logic [3:0]  L_JUMP_CNT = 4'(JUMP_FRAMES);
  localparam logic [5:0]  L_FALL_MAX = 6'(MAX_FALL_V);
  localparam logic [10:0] L_SCROLL   = 11'(SCROLL_X);
  localparam logic [10:0] L_FLOOR    = 11'(Y_FLOOR);

  function automatic logic [9:0] sub_clamp(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? 10'd0 : a - b;
  endfunction

  function automatic logic [9:0] inc_clamp(input logic [9:0] a);
    return (a == 10'h3FF) ? a : a + 10'd1;
  endfunction

  function automatic logic [5:0] inc_sat(input logic [5:0] v, input logic [5:0] cap);
    return (v >= cap) ? cap : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_floor(input logic [5:0] v);
    return (v == 6'd0) ? 6'd0 : v - 6'd1;
  endfunction

  function automatic logic [20:0] add_sat21(input logic [20:0] a, input logic [10:0] b);
    logic [21:0] s;
    s = {1'b0, a} + {11'd0, b};
    return s[21] ? 21'h1FFFFF : s[20:0];
  endfunction

  // Frame pulse: 2-FF synchronizer, edge detect, and a guard so a frame_clk that is
  // already high when reset releases is not mistaken for a fresh rising edge.
  logic r_fs1, r_fs2, r_fs3, r_sync_live, r_sync_arm, r_upd;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fs1       <= 1'b0;
      r_fs2       <= 1'b0;
      r_fs3       <= 1'b0;
      r_sync_live <= 1'b0;
      r_sync_arm  <= 1'b0;
      r_upd       <= 1'b0;
    end else begin
      r_fs1       <= frame_clk;
      r_fs2       <= r_fs1;
      r_fs3       <= r_fs2;
      r_sync_live <= 1'b1;
      r_sync_arm  <= r_sync_arm | (r_sync_live & ~r_fs1);
      r_upd       <= r_fs2 & ~r_fs3 & r_sync_arm;
    end
  end

  logic [9:0]  r_x, r_y;
  logic [5:0]  r_rv, r_lv, r_up, r_dn;
  logic [20:0] r_lx;
  state_t      r_st;
  logic [3:0]  r_cnt;
  logic        r_arm, r_og;

  logic [9:0]  w_x_n, w_y_n;
  logic [5:0]  w_rv_n, w_lv_n, w_up_n, w_dn_n;
  logic [5:0]  w_rv_k, w_lv_k, w_dn_k;
  logic [20:0] w_lx_n;
  state_t      w_st_n;
  logic [3:0]  w_cnt_n;
  logic        w_arm_n;
  logic [10:0] w_xsum, w_ysum;

  always_comb begin
    w_rv_k = r_rv;
    w_lv_k = r_lv;
    if (key_right && !key_left) begin
      if (r_lv != 6'd0) w_lv_k = r_lv - 6'd1;
      else              w_rv_k = inc_sat(r_rv, L_RUN_MAX);
    end else if (key_left && !key_right) begin
      if (r_rv != 6'd0) w_rv_k = r_rv - 6'd1;
      else              w_lv_k = inc_sat(r_lv, L_RUN_MAX);
    end else begin
      w_rv_k = dec_floor(r_rv);
      w_lv_k = dec_floor(r_lv);
    end

    w_xsum = {1'b0, r_x} + {5'd0, w_rv_k};
    w_rv_n = w_rv_k;
    w_lv_n = w_lv_k;
    w_x_n  = r_x;
    w_lx_n = r_lx;
    if (rightFlag && leftFlag) begin
      w_rv_n = 6'd0;
      w_lv_n = 6'd0;
    end else if (rightFlag) begin
      w_rv_n = 6'd0;
      w_x_n  = sub_clamp(collision_right, 10'd16);
    end else if (leftFlag) begin
      w_lv_n = 6'd0;
      w_x_n  = inc_clamp(collision_left);
    end else if (w_rv_k != 6'd0) begin
      // Past the scroll line the sprite parks and the world moves instead.
      if (w_xsum > L_SCROLL) begin
        w_x_n  = L_SCROLL[9:0];
        w_lx_n = add_sat21(r_lx, w_xsum - L_SCROLL);
      end else begin
        w_x_n  = w_xsum[9:0];
      end
    end else if (w_lv_k != 6'd0) begin
      w_x_n = sub_clamp(r_x, {4'd0, w_lv_k});
    end
  end

  always_comb begin
    w_st_n  = r_st;
    w_up_n  = r_up;
    w_dn_n  = r_dn;
    w_y_n   = r_y;
    w_cnt_n = r_cnt;
    w_arm_n = r_arm;
    w_dn_k  = inc_sat(r_dn, L_FALL_MAX);
    w_ysum  = {1'b0, r_y} + {5'd0, w_dn_k};
    case (r_st)
      GROUND: begin
        w_up_n = 6'd0;
        w_dn_n = 6'd0;
        if (!key_jump) w_arm_n = 1'b1;
        if (key_jump && r_arm) begin
          w_st_n  = RISE;
          w_up_n  = L_JUMP_V;
          w_cnt_n = L_JUMP_CNT;
          w_arm_n = 1'b0;
        end else if (!downFlag) begin
          w_st_n = FALL;
          w_dn_n = 6'd1;
        end
      end
      RISE: begin
        w_y_n   = sub_clamp(r_y, {4'd0, r_up});
        w_cnt_n = r_cnt - 4'd1;
        if (!key_jump) w_up_n = dec_floor(r_up);
        if (upFlag) begin
          w_y_n  = inc_clamp(collision_up);
          w_up_n = 6'd0;
          w_dn_n = 6'd1;
          w_st_n = FALL;
        end else if (w_cnt_n == 4'd0 || w_up_n == 6'd0) begin
          w_up_n = 6'd0;
          w_dn_n = 6'd1;
          w_st_n = FALL;
        end
      end
      FALL: begin
        // A collision snap takes priority over the floor clamp on the same frame.
        if (downFlag) begin
          w_y_n  = sub_clamp(collision_down, 10'd16);
          w_dn_n = 6'd0;
          w_st_n = GROUND;
        end else if (w_ysum >= L_FLOOR) begin
          w_y_n  = L_FLOOR[9:0];
          w_dn_n = 6'd0;
          w_st_n = GROUND;
        end else begin
          w_y_n  = w_ysum[9:0];
          w_dn_n = w_dn_k;
        end
      end
      default: w_st_n = FALL;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x   <= L_X0;
      r_y   <= L_Y0;
      r_rv  <= 6'd0;
      r_lv  <= 6'd0;
      r_up  <= 6'd0;
      r_dn  <= 6'd0;
      r_lx  <= 21'd0;
      r_st  <= FALL;
      r_cnt <= 4'd0;
      r_arm <= 1'b0;
      r_og  <= 1'b0;
    end else if (r_upd) begin
      r_x   <= w_x_n;
      r_y   <= w_y_n;
      r_rv  <= w_rv_n;
      r_lv  <= w_lv_n;
      r_up  <= w_up_n;
      r_dn  <= w_dn_n;
      r_lx  <= w_lx_n;
      r_st  <= w_st_n;
      r_cnt <= w_cnt_n;
      r_arm <= w_arm_n;
      r_og  <= (w_st_n == GROUND);
    end
  end

  assign X_Pos     = r_x;
  assign Y_Pos     = r_y;
  assign Right_V   = r_rv;
  assign Left_V    = r_lv;
  assign Up_V      = r_up;
  assign Down_V    = r_dn;
  assign logicalX  = r_lx;
  assign on_ground = r_og;

endmodule

// File: tb/tb_mario_motion.sv
// Directed and randomized frames for mario_motion, checked against a frame-level
// behavioural model of the player's motion rules.
module tb_mario_motion;

  logic        Clk, Reset_n, frame_clk;
  logic        key_left, key_right, key_jump;
  logic        rightFlag, leftFlag, upFlag, downFlag;
  logic [9:0]  collision_right, collision_left, collision_up, collision_down;
  logic [9:0]  X_Pos, Y_Pos;
  logic [5:0]  Right_V, Left_V, Up_V, Down_V;
  logic [20:0] logicalX;
  logic        on_ground;

  mario_motion dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .rightFlag(rightFlag), .leftFlag(leftFlag), .upFlag(upFlag), .downFlag(downFlag),
    .collision_right(collision_right), .collision_left(collision_left),
    .collision_up(collision_up), .collision_down(collision_down),
    .X_Pos(X_Pos), .Y_Pos(Y_Pos), .Right_V(Right_V), .Left_V(Left_V),
    .Up_V(Up_V), .Down_V(Down_V), .logicalX(logicalX), .on_ground(on_ground)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model state, plain integers; phase 0 = on ground, 1 = rising, 2 = falling.
  int m_x, m_y, m_rv, m_lv, m_up, m_dn, m_cnt, m_ph;
  bit m_armed;
  longint m_lx;

  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 32; m_y = 400; m_rv = 0; m_lv = 0; m_up = 0; m_dn = 0;
    m_lx = 0; m_ph = 2; m_cnt = 0; m_armed = 0;
  endtask

  task automatic model_frame();
    int rv, lv;
    rv = m_rv; lv = m_lv;
    if (key_right && !key_left) begin
      if (lv > 0) lv--; else rv = imin(rv + 1, 4);
    end else if (key_left && !key_right) begin
      if (rv > 0) rv--; else lv = imin(lv + 1, 4);
    end else begin
      rv = imax(rv - 1, 0); lv = imax(lv - 1, 0);
    end
    if (rightFlag && leftFlag) begin rv = 0; lv = 0; end
    else if (rightFlag) begin rv = 0; m_x = imax(int'(collision_right) - 16, 0); end
    else if (leftFlag) begin lv = 0; m_x = imin(int'(collision_left) + 1, 1023); end
    else if (rv > 0) begin
      if (m_x + rv > 320) begin
        m_lx = m_lx + (m_x + rv - 320);
        if (m_lx > 64'd2097151) m_lx = 2097151;
        m_x = 320;
      end else m_x = m_x + rv;
    end else if (lv > 0) m_x = imax(m_x - lv, 0);
    m_rv = rv; m_lv = lv;

    if (m_ph == 0) begin
      m_up = 0; m_dn = 0;
      if (key_jump && m_armed) begin
        m_ph = 1; m_up = 8; m_cnt = 12; m_armed = 0;
      end else begin
        if (!key_jump) m_armed = 1;
        if (!downFlag) begin m_ph = 2; m_dn = 1; end
      end
    end else if (m_ph == 1) begin
      m_y = imax(m_y - m_up, 0);
      m_cnt--;
      if (!key_jump) m_up = imax(m_up - 1, 0);
      if (upFlag) begin
        m_y = imin(int'(collision_up) + 1, 1023); m_up = 0; m_dn = 1; m_ph = 2;
      end else if (m_cnt == 0 || m_up == 0) begin
        m_up = 0; m_dn = 1; m_ph = 2;
      end
    end else begin
      m_dn = imin(m_dn + 1, 8);
      if (downFlag) begin
        m_y = imax(int'(collision_down) - 16, 0); m_dn = 0; m_ph = 0;
      end else if (m_y + m_dn >= 463) begin
        m_y = 463; m_dn = 0; m_ph = 0;
      end else m_y = m_y + m_dn;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_x"}, 32'(X_Pos), m_x);
    chk({tag, "_y"}, 32'(Y_Pos), m_y);
    chk({tag, "_rv"}, 32'(Right_V), m_rv);
    chk({tag, "_lv"}, 32'(Left_V), m_lv);
    chk({tag, "_up"}, 32'(Up_V), m_up);
    chk({tag, "_dn"}, 32'(Down_V), m_dn);
    chk({tag, "_lx"}, 32'(logicalX), 32'(m_lx));
    chk({tag, "_og"}, 32'(on_ground), (m_ph == 0) ? 32'd1 : 32'd0);
  endtask

  // One frame: inputs held for the whole frame; outputs must still show the previous
  // frame three edges after frame_clk rises and the new frame one edge later.
  task automatic frame(input string tag, input logic kl, kr, kj, rf, lf, uf, df,
                       input logic [9:0] cr, cl, cu, cd);
    key_left = kl; key_right = kr; key_jump = kj;
    rightFlag = rf; leftFlag = lf; upFlag = uf; downFlag = df;
    collision_right = cr; collision_left = cl; collision_up = cu; collision_down = cd;
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    chk({tag, "_hold_x"}, 32'(X_Pos), m_x);
    chk({tag, "_hold_y"}, 32'(Y_Pos), m_y);
    model_frame();
    @(negedge Clk);
    check_all(tag);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0;
    key_left = 0; key_right = 0; key_jump = 0;
    rightFlag = 0; leftFlag = 0; upFlag = 0; downFlag = 0;
    collision_right = 0; collision_left = 0; collision_up = 0; collision_down = 0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_all("reset");
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    // Run right from rest.
    for (int i = 0; i < 4; i++) begin
      frame("run", 0, 1, 0, 0, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
      chk("run_rv_tp", 32'(Right_V), i + 1);
      chk("run_x_tp", 32'(X_Pos), (i == 0) ? 33 : (i == 1) ? 35 : (i == 2) ? 38 : 42);
    end

    // Park at X=318 against a left wall while building speed, then cross the scroll line.
    for (int i = 0; i < 4; i++)
      frame("park", 0, 1, 0, 0, 1, 0, 0, 10'd0, 10'd317, 10'd0, 10'd0);
    chk("park_x_tp", 32'(X_Pos), 318);
    frame("scroll1", 0, 1, 0, 0, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
    chk("scroll1_x_tp", 32'(X_Pos), 320);
    chk("scroll1_lx_tp", 32'(logicalX), 2);
    frame("scroll2", 0, 1, 0, 0, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
    chk("scroll2_x_tp", 32'(X_Pos), 320);
    chk("scroll2_lx_tp", 32'(logicalX), 6);

    // Land at Y=400, arm, then hold jump for 20 frames.
    frame("land", 0, 0, 0, 0, 0, 0, 1, 10'd0, 10'd0, 10'd0, 10'd416);
    frame("arm", 0, 0, 0, 0, 0, 0, 1, 10'd0, 10'd0, 10'd0, 10'd416);
    chk("arm_og_tp", 32'(on_ground), 1);
    frame("jump", 0, 0, 1, 0, 0, 0, 1, 10'd0, 10'd0, 10'd0, 10'd416);
    chk("jump_up_tp", 32'(Up_V), 8);
    for (int i = 1; i < 20; i++) begin
      frame("hold", 0, 0, 1, 0, 0, 0, 1, 10'd0, 10'd0, 10'd0, 10'd416);
      if (i < 12) chk("hold_up_tp", 32'(Up_V), 8);
      if (i == 12) begin
        chk("apex_y_tp", 32'(Y_Pos), 304);
        chk("apex_up_tp", 32'(Up_V), 0);
        chk("apex_dn_tp", 32'(Down_V), 1);
        chk("apex_og_tp", 32'(on_ground), 0);
      end
      if (i >= 14) begin
        chk("norejump_og_tp", 32'(on_ground), 1);
        chk("norejump_up_tp", 32'(Up_V), 0);
      end
    end

    // Walk off into a fall, accelerate to Down_V=5, then snap onto a platform.
    frame("walkoff", 0, 0, 0, 0, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
    for (int i = 0; i < 4; i++)
      frame("fall", 0, 0, 0, 0, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
    chk("fall_dn_tp", 32'(Down_V), 5);
    frame("snap", 0, 0, 0, 0, 0, 0, 1, 10'd0, 10'd0, 10'd0, 10'd400);
    chk("snap_y_tp", 32'(Y_Pos), 384);
    chk("snap_dn_tp", 32'(Down_V), 0);
    chk("snap_og_tp", 32'(on_ground), 1);

    // Jump into a ceiling.
    frame("jump2", 0, 0, 1, 0, 0, 0, 1, 10'd0, 10'd0, 10'd0, 10'd400);
    frame("ceil", 0, 0, 1, 0, 0, 1, 0, 10'd0, 10'd0, 10'd200, 10'd0);
    chk("ceil_y_tp", 32'(Y_Pos), 201);
    chk("ceil_up_tp", 32'(Up_V), 0);
    chk("ceil_dn_tp", 32'(Down_V), 1);
    chk("ceil_og_tp", 32'(on_ground), 0);

    // Asynchronous reset in the middle of a fall.
    @(negedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    chk("arst_x", 32'(X_Pos), 32);
    chk("arst_y", 32'(Y_Pos), 400);
    chk("arst_lx", 32'(logicalX), 0);
    model_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    check_all("post_rst");

    // Wedged between two walls.
    frame("step", 0, 1, 0, 0, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
    frame("wedge", 0, 1, 0, 1, 1, 0, 0, 10'd500, 10'd10, 10'd0, 10'd0);
    chk("wedge_rv_tp", 32'(Right_V), 0);
    chk("wedge_x_tp", 32'(X_Pos), 33);

    // Random play.
    for (int i = 0; i < 150; i++) begin
      frame("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
            10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mario_motion.md
# mario_motion

Per-frame player motion controller for the Mario sprite. Consumes the four directional collision flags and nearest-collision coordinates produced by the collision stage and outputs the player's next screen position, the unsigned directional velocities, and the world scroll offset `logicalX`. The collision stage reads all of these on the following frame. Runs on the 50 MHz system clock and updates once per video frame.

## Interface

**Parameters**
- `X_START`, 32: reset X_Pos.
- `Y_START`, 400: reset Y_Pos.
- `MAX_RUN_V`, 4: horizontal speed cap.
- `JUMP_V`, 8: initial Up_V on jump.
- `JUMP_FRAMES`, 12: maximum frames in RISE.
- `MAX_FALL_V`, 8: Down_V cap.
- `SCROLL_X`, 320: screen X beyond which rightward motion scrolls the world instead.
- `Y_FLOOR`, 463: lowest legal Y_Pos.

**Ports** (clock and reset first)
- `Clk` in 1: 50 MHz system clock, the only clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_clk` in 1: vsync-rate signal, treated as asynchronous data.
- `key_left`, `key_right`, `key_jump` in 1 each: decoded keyboard levels.
- `rightFlag`, `leftFlag`, `upFlag`, `downFlag` in 1 each: collision flags.
- `collision_right`, `collision_left`, `collision_up`, `collision_down` in 10 each: nearest blocking pixel coordinates.
- `X_Pos`, `Y_Pos` out 10 each: sprite top-left on screen.
- `Right_V`, `Left_V`, `Up_V`, `Down_V` out 6 each: unsigned directional speeds.
- `logicalX` out 21: world scroll offset in pixels.
- `on_ground` out 1: high in GROUND.

## Operation

**Frame pulse**
- `frame_clk` passes through a 2-FF synchronizer followed by rising-edge detection, producing a one-cycle `upd` pulse.
- All state and outputs change only on `upd` cycles.

**Horizontal**
- At most one of Right_V and Left_V is nonzero at any time.
- Right pressed alone: if Left_V>0, decrement Left_V; otherwise increment Right_V, saturating at MAX_RUN_V. Left pressed alone is symmetric.
- Neither or both keys pressed: decrement whichever velocity is nonzero by 1 (friction).
- `rightFlag`: Right_V←0 and X_Pos←collision_right−16.
- `leftFlag`: Left_V←0 and X_Pos←collision_left+1.
- Both flags set: both velocities ←0, X_Pos unchanged.
- No flag, moving right: if X_Pos+Right_V > SCROLL_X, then X_Pos←SCROLL_X and logicalX += (X_Pos+Right_V−SCROLL_X). Otherwise X_Pos += Right_V.
- No flag, moving left: X_Pos −= Left_V, clamped at 0. logicalX never decreases.
- logicalX saturates at 2^21−1.

**Vertical FSM** (states GROUND, RISE, FALL, with a 4-bit `jump_cnt` and a `jump_armed` bit)
- GROUND:
  - Up_V=Down_V=0. `jump_armed` is set while key_jump=0.
  - key_jump=1 with jump_armed=1 → RISE: Up_V←JUMP_V, jump_cnt←JUMP_FRAMES, jump_armed←0.
  - Otherwise, downFlag=0 → FALL with Down_V←1.
  - If both conditions hold, the jump wins.
- RISE:
  - Each frame: Y_Pos −= Up_V (clamped at 0) and jump_cnt decrements.
  - If key_jump=0, Up_V also decrements by 1 (short hop).
  - `upFlag` → Y_Pos←collision_up+1, Up_V←0, go to FALL with Down_V←1.
  - jump_cnt reaches 0 or Up_V reaches 0 → FALL with Down_V←1, Up_V←0.
- FALL:
  - Each frame: Down_V increments, saturating at MAX_FALL_V, and Y_Pos += Down_V, clamped at Y_FLOOR.
  - `downFlag` → Y_Pos←collision_down−16, Down_V←0, go to GROUND.
  - Reaching Y_FLOOR also goes to GROUND.
  - If downFlag and Y_FLOOR coincide, the downFlag snap value is used.

**Arithmetic**
- Position sums are computed 11 bits wide before clamping; no wrap-around of X_Pos or Y_Pos is permitted.

## Timing

- Reset values (asynchronous): X_Pos=X_START, Y_Pos=Y_START, all velocities 0, logicalX=0, FSM=FALL, jump_cnt=0, jump_armed=0, on_ground=0, synchronizer flops=0.
- Latency: `upd` asserts on the 3rd Clk edge after `frame_clk` rises. Outputs are registered and valid on the edge following `upd`, then held constant for the rest of the frame.
- Flags and collision coordinates are sampled only on the `upd` cycle.
- Reset_n asserted mid-frame returns all state to reset values immediately. No `upd` is generated until frame_clk produces a fresh rising edge after release.

## Test plan

- Reset, then 4 frames with key_right=1 and no flags → Right_V=1,2,3,4; X_Pos=33,35,38,42.
- X_Pos=318, Right_V=4, key_right=1, one frame → X_Pos=320, logicalX=2. The next frame gives logicalX=6 with X_Pos still 320.
- GROUND, downFlag=1, key_jump pulse held 20 frames → RISE, Up_V=8 for 12 frames, Y_Pos falls by 96, then FALL. Holding jump after landing does not re-jump.
- FALL with Down_V=5, downFlag=1, collision_down=400 → Y_Pos=384, Down_V=0, on_ground=1.
- RISE, upFlag=1, collision_up=200 → Y_Pos=201, Up_V=0, FALL with Down_V=1.
- Reset_n pulsed low mid-FALL → X_Pos=32, Y_Pos=400, logicalX=0 on the same cycle. Both side flags set with key_right=1 → Right_V=0 and X_Pos unchanged.
